plot_arbiter: RTL

- Merges the two pixel-write streams, bird sprite drawer and hunter/crosshair drawer, into the single `x`/`y`/`colour`/`plot` write port of one 160x120 `vga_adapter`.
- Each source offers pixels over a valid/ready handshake and marks the final pixel of a sprite with `last`.
- Grants are held for a whole sprite, so two sprites never interleave.
- Writes with out-of-range coordinates are dropped and counted.

---
 rtl/plot_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/plot_arbiter.sv
// plot_arbiter: merges the bird and hunter pixel streams into the single
// write port of a 160x120 vga_adapter. Grants last a whole sprite, ties are
// broken round-robin, and off-screen pixels are discarded and counted.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no grant; pick a source from the current valids
// S_GRANT_A | bird drawer owns the port until its last pixel or timeout
// S_GRANT_B | hunter drawer owns the port until its last pixel or timeout
module plot_arbiter #(
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120,
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] a_x,
  input  logic [6:0] a_y,
  input  logic [2:0] a_colour,
  input  logic       a_last,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [7:0] b_x,
  input  logic [6:0] b_y,
  input  logic [2:0] b_colour,
  input  logic       b_last,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [7:0] drop_count
);

  // One extra bit so the limits may equal the full port range.
  localparam logic [8:0] X_LIM   = 9'(X_MAX);
  localparam logic [7:0] Y_LIM   = 8'(Y_MAX);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_A = 2'd1,
    S_GRANT_B = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last_served;
  logic       w_last_served_nxt;
  logic [7:0] r_idle_cnt;
  logic [7:0] w_idle_cnt_nxt;

  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic [7:0] r_drop_count;

  logic       w_xfer_a;
  logic       w_xfer_b;
  logic       w_xfer;
  logic [7:0] w_sel_x;
  logic [6:0] w_sel_y;
  logic [2:0] w_sel_colour;
  logic       w_in_range;

  // Ready depends on state alone so sources can never form a comb loop.
  assign a_ready  = (r_state == S_GRANT_A);
  assign b_ready  = (r_state == S_GRANT_B);

  assign w_xfer_a = a_valid & a_ready;
  assign w_xfer_b = b_valid & b_ready;
  assign w_xfer   = w_xfer_a | w_xfer_b;

  assign w_sel_x      = (r_state == S_GRANT_B) ? b_x      : a_x;
  assign w_sel_y      = (r_state == S_GRANT_B) ? b_y      : a_y;
  assign w_sel_colour = (r_state == S_GRANT_B) ? b_colour : a_colour;

  // Unsigned compare: coordinates that wrapped below zero land high and drop.
  assign w_in_range = ({1'b0, w_sel_x} < X_LIM) && ({1'b0, w_sel_y} < Y_LIM);

  // Arbitration state, round-robin pointer and grant idle timer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_served <= SRC_B;
      r_idle_cnt    <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_served <= w_last_served_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
    end
  end

  // Next-state logic: pick a source, hold it for a sprite, release on last or timeout.
  always_comb begin
    w_state_nxt       = r_state;
    w_last_served_nxt = r_last_served;
    w_idle_cnt_nxt    = r_idle_cnt;
    case (r_state)
      S_IDLE: begin
        w_idle_cnt_nxt = 8'd0;
        if (a_valid && b_valid) begin
          w_state_nxt = (r_last_served == SRC_B) ? S_GRANT_A : S_GRANT_B;
        end else if (a_valid) begin
          w_state_nxt = S_GRANT_A;
        end else if (b_valid) begin
          w_state_nxt = S_GRANT_B;
        end
      end
      S_GRANT_A: begin
        if (w_xfer_a) begin
          w_idle_cnt_nxt = 8'd0;
          if (a_last) begin
            w_last_served_nxt = SRC_A;
            w_state_nxt       = b_valid ? S_GRANT_B : S_IDLE;
          end
        end else if (r_idle_cnt == TO_LAST) begin
          w_idle_cnt_nxt    = 8'd0;
          w_last_served_nxt = SRC_A;
          w_state_nxt       = S_IDLE;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + 8'd1;
        end
      end
      S_GRANT_B: begin
        if (w_xfer_b) begin
          w_idle_cnt_nxt = 8'd0;
          if (b_last) begin
            w_last_served_nxt = SRC_B;
            w_state_nxt       = a_valid ? S_GRANT_A : S_IDLE;
          end
        end else if (r_idle_cnt == TO_LAST) begin
          w_idle_cnt_nxt    = 8'd0;
          w_last_served_nxt = SRC_B;
          w_state_nxt       = S_IDLE;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_idle_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Output register: latch on-screen pixels, strobe plot, count drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x          <= 8'd0;
      r_y          <= 7'd0;
      r_colour     <= 3'd0;
      r_plot       <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      r_plot <= 1'b0;
      if (w_xfer) begin
        if (w_in_range) begin
          r_x      <= w_sel_x;
          r_y      <= w_sel_y;
          r_colour <= w_sel_colour;
          r_plot   <= 1'b1;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign colour     = r_colour;
  assign plot       = r_plot;
  assign drop_count = r_drop_count;

endmodule
